vga_fb_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 21 ++
 rtl/fb_ram.sv | 22 ++
 rtl/vga_fb_scanout.sv | 165 ++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer scanout.
// 640x480 screen timing over a 320x240 3-bit framebuffer.
package vga_pkg;

   localparam int H_TOTAL  = 800;
   localparam int H_ACTIVE = 640;
   localparam int V_TOTAL  = 525;
   localparam int V_ACTIVE = 480;
   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int FB_DEPTH = 76800;

   typedef logic [2:0]  rgb_t;
   typedef logic [16:0] fb_addr_t;

   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM, registered read.
// Read-during-write to one address returns the old data.
module fb_ram
   import vga_pkg::*;
(
   input  logic     clock,
   input  logic     wrEn,
   input  fb_addr_t wrAddr,
   input  rgb_t     wrData,
   input  fb_addr_t rdAddr,
   output rgb_t     rdData
);

   rgb_t mem [FB_DEPTH];

   always_ff @(posedge clock) begin
      if (wrEn)
         mem[wrAddr] <= wrData;
      rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout at 2x scale with host write port and bulk clear.
// RGB and syncs leave together, LATENCY clocks after the counters.
module vga_fb_scanout
   import vga_pkg::*;
#(
   parameter int LATENCY        = 2,
   parameter bit CLEAR_ON_RESET = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [10:0] hor_cnt,
   input  logic [9:0]  ver_cnt,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        wr_en,
   input  logic [16:0] wr_addr,
   input  logic [2:0]  wr_data,
   input  logic        clear_req,
   input  logic [2:0]  clear_color,
   output logic        clear_busy,
   output logic        red,
   output logic        green,
   output logic        blue,
   output logic        vga_hsync_n,
   output logic        vga_vsync_n
);

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
   localparam fb_addr_t    LINE_W  = 17'(FB_W);
   localparam fb_addr_t    FB_END  = 17'(FB_DEPTH);
   localparam fb_addr_t    FB_LAST = 17'(FB_DEPTH - 1);

   fb_addr_t   rdAddr;
   fb_addr_t   lineBase;
   logic       active;
   logic       activeD1;
   rgb_t       ramData;
   rgb_t       rgbQ;
   logic [LATENCY-1:0] hsPipe;
   logic [LATENCY-1:0] vsPipe;

   clr_state_t state;
   clr_state_t stateNxt;
   fb_addr_t   clrAddr;
   fb_addr_t   clrAddrNxt;
   rgb_t       clrColor;
   rgb_t       clrColorNxt;
   logic       startPend;
   logic       clrGo;
   rgb_t       clrIn;

   logic       ramWe;
   fb_addr_t   ramWa;
   rgb_t       ramWd;

   assign active = (hor_cnt < H_ACT) && (ver_cnt < V_ACT);

   // Each stored line is replayed for two screen lines.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdAddr   <= '0;
         lineBase <= '0;
      end else if (hor_cnt == H_LAST) begin
         if (ver_cnt == V_LAST) begin
            lineBase <= '0;
            rdAddr   <= '0;
         end else if (ver_cnt[0] && (ver_cnt < V_ACT)) begin
            lineBase <= lineBase + LINE_W;
            rdAddr   <= lineBase + LINE_W;
         end else begin
            rdAddr <= lineBase;
         end
      end else if (active && hor_cnt[0]) begin
         rdAddr <= rdAddr + 17'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         activeD1 <= 1'b0;
         rgbQ     <= '0;
         hsPipe   <= '0;
         vsPipe   <= '0;
      end else begin
         activeD1 <= active;
         rgbQ     <= activeD1 ? ramData : '0;
         hsPipe   <= {hsPipe[LATENCY-2:0], hsync_in};
         vsPipe   <= {vsPipe[LATENCY-2:0], vsync_in};
      end
   end

   assign red         = rgbQ[0];
   assign green       = rgbQ[1];
   assign blue        = rgbQ[2];
   assign vga_hsync_n = ~hsPipe[LATENCY-1];
   assign vga_vsync_n = ~vsPipe[LATENCY-1];

   assign clrGo      = clear_req | startPend;
   assign clrIn      = startPend ? '0 : clear_color;
   assign clear_busy = (state == CLEAR);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         clrAddr   <= '0;
         clrColor  <= '0;
         startPend <= CLEAR_ON_RESET;
      end else begin
         state     <= stateNxt;
         clrAddr   <= clrAddrNxt;
         clrColor  <= clrColorNxt;
         startPend <= 1'b0;
      end
   end

   always_comb begin
      stateNxt    = state;
      clrAddrNxt  = clrAddr;
      clrColorNxt = clrColor;
      unique case (state)
         IDLE: begin
            if (clrGo) begin
               stateNxt    = CLEAR;
               clrAddrNxt  = '0;
               clrColorNxt = clrIn;
            end
         end
         CLEAR: begin
            clrAddrNxt = clrAddr + 17'd1;
            if (clrAddr == FB_LAST) begin
               stateNxt   = IDLE;
               clrAddrNxt = '0;
            end
         end
      endcase
   end

   // The clear engine owns the write port; host writes are dropped meanwhile.
   always_comb begin
      ramWe = 1'b0;
      ramWa = wr_addr;
      ramWd = wr_data;
      unique case (1'b1)
         clear_busy: begin
            ramWe = 1'b1;
            ramWa = clrAddr;
            ramWd = clrColor;
         end
         default: ramWe = wr_en && (wr_addr < FB_END);
      endcase
   end

   fb_ram uRam (
      .clock  (clock),
      .wrEn   (ramWe),
      .wrAddr (ramWa),
      .wrData (ramWd),
      .rdAddr (rdAddr),
      .rdData (ramData)
   );

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout.
// Pixels are driven one per clock; outputs are checked two clocks later.
module tb_vga_fb_scanout;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [10:0] hor_cnt;
   logic [9:0]  ver_cnt;
   logic        hsync_in;
   logic        vsync_in;
   logic        wr_en;
   logic [16:0] wr_addr;
   logic [2:0]  wr_data;
   logic        clear_req;
   logic [2:0]  clear_color;
   logic        clear_busy;
   logic        red;
   logic        green;
   logic        blue;
   logic        vga_hsync_n;
   logic        vga_vsync_n;

   int tests = 0;
   int fails = 0;

   bit         hV [2];
   logic [2:0] hE [2];
   logic       hH [2];
   logic       hS [2];
   int         hX [2];
   int         hY [2];

   int cnt;

   vga_fb_scanout dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .hor_cnt     (hor_cnt),
      .ver_cnt     (ver_cnt),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .clear_req   (clear_req),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .vga_hsync_n (vga_hsync_n),
      .vga_vsync_n (vga_vsync_n)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic idle();
      hV[0]    = 1'b0;
      hV[1]    = 1'b0;
      hor_cnt  = 11'd700;
      ver_cnt  = 10'd0;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
   endtask

   task automatic px(input int h, input int v, input logic hs,
                     input logic vs, input bit chk, input logic [2:0] e);
      @(negedge clock);
      if (hV[1]) begin
         check($sformatf("rgb(%0d,%0d)", hX[1], hY[1]),
               {29'd0, blue, green, red}, {29'd0, hE[1]});
         check($sformatf("hsn(%0d,%0d)", hX[1], hY[1]),
               {31'd0, vga_hsync_n}, {31'd0, ~hH[1]});
         check($sformatf("vsn(%0d,%0d)", hX[1], hY[1]),
               {31'd0, vga_vsync_n}, {31'd0, ~hS[1]});
      end
      hV[1] = hV[0]; hE[1] = hE[0]; hH[1] = hH[0];
      hS[1] = hS[0]; hX[1] = hX[0]; hY[1] = hY[0];
      hV[0] = chk; hE[0] = e; hH[0] = hs;
      hS[0] = vs; hX[0] = h; hY[0] = v;
      hor_cnt  = 11'(h);
      ver_cnt  = 10'(v);
      hsync_in = hs;
      vsync_in = vs;
   endtask

   task automatic flush();
      px(700, 0, 1'b0, 1'b0, 1'b1, 3'b000);
      px(700, 0, 1'b0, 1'b0, 1'b1, 3'b000);
      px(700, 0, 1'b0, 1'b0, 1'b0, 3'b000);
      px(700, 0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic wr(input int addr, input logic [2:0] d);
      @(negedge clock);
      idle();
      wr_en   = 1'b1;
      wr_addr = 17'(addr);
      wr_data = d;
      @(negedge clock);
      wr_en   = 1'b0;
   endtask

   // Walk line_base up to the last stored line, then scan screen line 479.
   task automatic toLast(input logic [2:0] e);
      px(799, 524, 1'b0, 1'b0, 1'b0, 3'b000);
      for (int v = 1; v < 479; v += 2)
         px(799, v, 1'b0, 1'b0, 1'b0, 3'b000);
      for (int h = 0; h < 640; h++)
         px(h, 479, 1'b0, 1'b0, (h >= 638), e);
      px(799, 479, 1'b0, 1'b0, 1'b1, 3'b000);
      flush();
   endtask

   initial begin
      reset_n     = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      clear_req   = 1'b0;
      clear_color = '0;
      idle();
      hsync_in    = 1'b1;
      vsync_in    = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_rgb", {29'd0, blue, green, red}, 32'd0);
      check("rst_hsn", {31'd0, vga_hsync_n}, 32'd1);
      check("rst_vsn", {31'd0, vga_vsync_n}, 32'd1);
      check("rst_busy", {31'd0, clear_busy}, 32'd0);
      idle();
      reset_n = 1'b1;

      // 2x scaling of the first two stored pixels and line doubling.
      wr(0, 3'b101);
      wr(1, 3'b010);
      wr(320, 3'b111);
      px(799, 524, 1'b0, 1'b0, 1'b0, 3'b000);
      px(0, 0, 1'b0, 1'b0, 1'b1, 3'b101);
      px(1, 0, 1'b0, 1'b0, 1'b1, 3'b101);
      px(2, 0, 1'b0, 1'b0, 1'b1, 3'b010);
      px(3, 0, 1'b0, 1'b0, 1'b1, 3'b010);
      px(799, 0, 1'b0, 1'b0, 1'b1, 3'b000);
      px(0, 1, 1'b0, 1'b0, 1'b1, 3'b101);
      px(1, 1, 1'b0, 1'b0, 1'b1, 3'b101);
      px(2, 1, 1'b0, 1'b0, 1'b1, 3'b010);
      px(3, 1, 1'b0, 1'b0, 1'b1, 3'b010);
      px(799, 1, 1'b0, 1'b0, 1'b1, 3'b000);
      px(0, 2, 1'b0, 1'b0, 1'b1, 3'b111);
      px(1, 2, 1'b0, 1'b0, 1'b1, 3'b111);
      px(640, 2, 1'b0, 1'b0, 1'b1, 3'b000);
      px(656, 2, 1'b1, 1'b0, 1'b1, 3'b000);
      px(657, 2, 1'b0, 1'b0, 1'b1, 3'b000);
      px(799, 2, 1'b0, 1'b0, 1'b1, 3'b000);
      px(0, 3, 1'b0, 1'b0, 1'b1, 3'b111);
      px(1, 3, 1'b0, 1'b0, 1'b1, 3'b111);
      px(0, 480, 1'b0, 1'b1, 1'b1, 3'b000);
      flush();

      // Out-of-range write dropped; last address and frame wrap.
      wr(76800, 3'b110);
      wr(76799, 3'b110);
      toLast(3'b110);
      px(799, 524, 1'b0, 1'b0, 1'b0, 3'b000);
      px(0, 0, 1'b0, 1'b0, 1'b1, 3'b101);
      px(1, 0, 1'b0, 1'b0, 1'b1, 3'b101);
      px(2, 0, 1'b0, 1'b0, 1'b1, 3'b010);
      flush();

      // Bulk clear: duration, blocked host write, ignored second request.
      @(negedge clock);
      idle();
      clear_color = 3'b011;
      clear_req   = 1'b1;
      @(negedge clock);
      clear_req   = 1'b0;
      clear_color = 3'b000;
      check("busy_start", {31'd0, clear_busy}, 32'd1);
      cnt = 1;
      for (int i = 0; i < 80000 && clear_busy; i++) begin
         wr_en       = (i == 100);
         wr_addr     = 17'd5;
         wr_data     = 3'b111;
         clear_req   = (i == 200);
         clear_color = 3'b111;
         @(negedge clock);
         if (clear_busy)
            cnt++;
      end
      wr_en     = 1'b0;
      clear_req = 1'b0;
      check("clear_len", cnt, 32'd76800);
      check("busy_end", {31'd0, clear_busy}, 32'd0);
      px(799, 524, 1'b0, 1'b0, 1'b0, 3'b000);
      for (int h = 0; h < 12; h++)
         px(h, 0, 1'b0, 1'b0, 1'b1, 3'b011);
      flush();
      toLast(3'b011);

      // Reset in the middle of a clear and of a line.
      @(negedge clock);
      idle();
      clear_color = 3'b110;
      clear_req   = 1'b1;
      @(negedge clock);
      clear_req   = 1'b0;
      repeat (1000) @(negedge clock);
      px(799, 524, 1'b0, 1'b0, 1'b0, 3'b000);
      px(0, 0, 1'b1, 1'b1, 1'b1, 3'b110);
      px(1, 0, 1'b1, 1'b1, 1'b1, 3'b110);
      px(2, 0, 1'b1, 1'b1, 1'b1, 3'b110);
      px(3, 0, 1'b1, 1'b1, 1'b1, 3'b110);
      check("pre_rst_busy", {31'd0, clear_busy}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_rgb", {29'd0, blue, green, red}, 32'd0);
      check("arst_hsn", {31'd0, vga_hsync_n}, 32'd1);
      check("arst_vsn", {31'd0, vga_vsync_n}, 32'd1);
      check("arst_busy", {31'd0, clear_busy}, 32'd0);
      idle();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      px(799, 524, 1'b0, 1'b0, 1'b0, 3'b000);
      px(0, 0, 1'b0, 1'b0, 1'b1, 3'b110);
      px(1, 0, 1'b0, 1'b0, 1'b1, 3'b110);
      px(2, 0, 1'b0, 1'b0, 1'b1, 3'b110);
      flush();
      check("post_rst_busy", {31'd0, clear_busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
